// File: rtl/mem_chk_pkg.sv
// Shared types and constants for the memory read checker.
package mem_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_DUP_ADDR = 2'd1;
    localparam logic [1:0] ERR_ZERO     = 2'd2;
    localparam logic [1:0] ERR_OVERLAP  = 2'd3;

endpackage

// File: rtl/mem_chk_lat_pipe.sv
// Delay line of {valid, addr} that lines an issued address up with the
// memory word returning DEPTH cycles later.
module mem_chk_lat_pipe #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    // Shift the request pair one stage per cycle; flush drops every pending valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            addr_q[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/mem_rd_checker.sv
// Watches a read-memory's address/data streams, pairs them through a latency
// pipe and checks for duplicate addresses, zero words and overlapping bits.
module mem_rd_checker
    import mem_chk_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int RD_LAT    = 1,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] dbits_mask
);

    localparam int              NUM_ADDR = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic [DATA_W-1:0]     mask_q, mask_d;
    logic [NUM_ADDR-1:0]   used_q, used_d;

    logic                  cap_valid;
    logic                  pipe_flush;
    logic                  pipe_valid;
    logic [ADDR_W-1:0]     pipe_addr;
    logic [DATA_W-1:0]     merged_mask;
    logic [ADDR_W:0]       count_inc;

    // Only addresses issued while running are tracked; anything in flight is
    // discarded whenever the checker is outside RUN or about to leave it.
    assign cap_valid   = rd_valid & (state_q == ST_RUN);
    assign pipe_flush  = (state_q != ST_RUN) | (state_d != ST_RUN);
    assign merged_mask = mask_q | rd_data;
    assign count_inc   = count_q + 1'b1;

    mem_chk_lat_pipe #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (pipe_flush),
        .in_valid  (cap_valid),
        .in_addr   (rd_addr),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr)
    );

    // Next-state logic: checks run in priority order and completion is only
    // considered for a word that passed every check.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        count_d    = count_q;
        mask_d     = mask_q;
        used_d     = used_q;
        case (state_q)
            ST_RUN: begin
                if (pipe_valid) begin
                    if (used_q[pipe_addr]) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_DUP_ADDR;
                    end else if (rd_data == '0) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_ZERO;
                    end else if ((mask_q & rd_data) != '0) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_OVERLAP;
                    end else begin
                        used_d[pipe_addr] = 1'b1;
                        mask_d            = merged_mask;
                        count_d           = count_inc;
                        if ((&merged_mask) || (count_inc == MAX_CNT)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d    = ST_RUN;
                    err_code_d = ERR_NONE;
                    count_d    = '0;
                    mask_d     = '0;
                    used_d     = '0;
                end
            end
        endcase
    end

    // Checker state and coverage registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            count_q    <= '0;
            mask_q     <= '0;
            used_q     <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            count_q    <= count_d;
            mask_q     <= mask_d;
            used_q     <= used_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign err_code   = err_code_q;
    assign word_count = count_q;
    assign dbits_mask = mask_q;

endmodule
